// File: rtl/seq_signed_divider_pkg.sv
// Shared definitions for the sequential signed divider: FSM state encodings and
// the iteration-counter width helper.
package seq_signed_divider_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    function automatic int cnt_width(input int wl);
        return (wl > 1) ? $clog2(wl) : 1;
    endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes: produces one
// quotient bit and the updated partial remainder.
module div_restore_step #(
    parameter int WL = 16
) (
    input  logic [WL-1:0] rem,
    input  logic [WL-1:0] quo,
    input  logic [WL-1:0] dvs,
    output logic [WL-1:0] rem_nxt,
    output logic [WL-1:0] quo_nxt
);

    logic [WL:0]   rem_sh;
    logic [WL-1:0] trial;
    logic          fits;

    assign rem_sh  = {rem, quo[WL-1]};
    // Partial remainder stays below the divisor, so a successful trial fits WL bits.
    assign trial   = rem_sh[WL-1:0] - dvs;
    assign fits    = (rem_sh >= {1'b0, dvs});
    assign rem_nxt = fits ? trial : rem_sh[WL-1:0];
    assign quo_nxt = {quo[WL-2:0], fits};

endmodule

// File: rtl/seq_signed_divider.sv
// Multi-cycle signed divider (truncating toward zero) with start/busy/done handshake;
// one restoring step per clock on operand magnitudes, sign fix-up in a final cycle.
module seq_signed_divider
    import seq_signed_divider_pkg::*;
#(
    parameter int WL = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic signed [WL-1:0] dividend,
    input  logic signed [WL-1:0] divisor,
    output logic                 busy,
    output logic                 done,
    output logic signed [WL-1:0] quotient,
    output logic signed [WL-1:0] remainder,
    output logic                 div_by_zero,
    output logic                 overflow
);

    localparam int            CNT_W    = cnt_width(WL);
    localparam logic [WL-1:0] MOST_NEG = {1'b1, {(WL-1){1'b0}}};

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WL-1:0]    rem_q, quo_q, dvs_q;
    logic [WL-1:0]    rem_nxt, quo_nxt;
    logic             sign_a, sign_b, zero_q, ovf_q;
    logic             accept;

    function automatic logic [WL-1:0] neg(input logic [WL-1:0] x);
        return ~x + WL'(1);
    endfunction

    // Magnitude of the most-negative value wraps to 2^(WL-1), which is exact as unsigned.
    function automatic logic [WL-1:0] mag(input logic signed [WL-1:0] x);
        return x[WL-1] ? neg(x) : x;
    endfunction

    assign accept = (state == S_IDLE) && start;

    div_restore_step #(.WL(WL)) u_step (
        .rem     (rem_q),
        .quo     (quo_q),
        .dvs     (dvs_q),
        .rem_nxt (rem_nxt),
        .quo_nxt (quo_nxt)
    );

    // Operand capture and iteration datapath
    always_ff @(posedge clk) begin
        if (accept) begin
            rem_q  <= '0;
            quo_q  <= mag(dividend);
            dvs_q  <= mag(divisor);
            sign_a <= dividend[WL-1];
            sign_b <= divisor[WL-1];
            zero_q <= (divisor == '0);
            ovf_q  <= (dividend == MOST_NEG) && (divisor == '1);
        end else if (state == S_CALC) begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
        end
    end

    // Control FSM and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_CALC;
                        cnt         <= CNT_W'(WL - 1);
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                    end
                end
                S_CALC: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == '0) state <= S_FIX;
                end
                S_FIX: begin
                    state       <= S_IDLE;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    quotient    <= zero_q ? '1 : ((sign_a ^ sign_b) ? neg(quo_q) : quo_q);
                    remainder   <= sign_a ? neg(rem_q) : rem_q;
                    div_by_zero <= zero_q;
                    overflow    <= ovf_q;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Bench for seq_signed_divider: cycle-accurate latency/arithmetic reference model
// compared every cycle, plus directed operations with literal expectations.
module tb_seq_signed_divider;

    localparam int WL  = 16;
    localparam int LAT = WL + 2;

    typedef struct packed {
        logic signed [WL-1:0] q;
        logic signed [WL-1:0] r;
        logic                 dbz;
        logic                 ovf;
    } res_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic signed [WL-1:0] dividend = '0;
    logic signed [WL-1:0] divisor = '0;
    logic                 busy, done, div_by_zero, overflow;
    logic signed [WL-1:0] quotient, remainder;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    seq_signed_divider #(.WL(WL)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    function automatic res_t mk(input int q, input int r, input bit dbz, input bit ovf);
        res_t t;
        t.q   = WL'(q);
        t.r   = WL'(r);
        t.dbz = dbz;
        t.ovf = ovf;
        return t;
    endfunction

    // Reference arithmetic using native truncating integer division.
    function automatic res_t ref_div(input logic signed [WL-1:0] a, input logic signed [WL-1:0] b);
        int ai;
        int bi;
        ai = a;
        bi = b;
        if (bi == 0)
            return mk(-1, ai, 1'b1, 1'b0);
        else if (ai == -(1 << (WL-1)) && bi == -1)
            return mk(ai, 0, 1'b0, 1'b1);
        else
            return mk(ai / bi, ai % bi, 1'b0, 1'b0);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Protocol-level model: an accepted op completes LAT-1 edges later.
    int   remain;
    logic m_busy, m_done;
    res_t m_res, p_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remain <= 0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_res  <= '0;
        end else begin
            m_done <= 1'b0;
            if (remain > 0) begin
                remain <= remain - 1;
                if (remain == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_res  <= p_res;
                end
            end else if (start) begin
                remain    <= LAT - 1;
                m_busy    <= 1'b1;
                m_res.dbz <= 1'b0;
                m_res.ovf <= 1'b0;
                p_res     <= ref_div(dividend, divisor);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (cmp_en) begin
            chk("cyc busy", busy, m_busy);
            chk("cyc done", done, m_done);
            chk("cyc quotient", quotient, m_res.q);
            chk("cyc remainder", remainder, m_res.r);
            chk("cyc div_by_zero", div_by_zero, m_res.dbz);
            chk("cyc overflow", overflow, m_res.ovf);
        end
    end

    task automatic launch(input int a, input int b);
        dividend = WL'(a);
        divisor  = WL'(b);
        start    = 1'b1;
    endtask

    task automatic wait_done(input bit drop, input int glitch, input res_t exp, input string tag);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) start = !drop;
            if (glitch > 0 && n == glitch) begin
                start    = 1'b1;
                dividend = WL'($urandom);
                divisor  = WL'($urandom);
            end
            if (glitch > 0 && n == glitch + 1) start = !drop;
            if (done) seen = 1'b1;
        end
        chk({tag, " latency"}, n, LAT);
        chk({tag, " quotient"}, quotient, exp.q);
        chk({tag, " remainder"}, remainder, exp.r);
        chk({tag, " div_by_zero"}, div_by_zero, exp.dbz);
        chk({tag, " overflow"}, overflow, exp.ovf);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " quotient"}, quotient, 0);
        chk({tag, " remainder"}, remainder, 0);
        chk({tag, " div_by_zero"}, div_by_zero, 0);
        chk({tag, " overflow"}, overflow, 0);
    endtask

    initial begin
        res_t e;
        int   a, b, sel, g;
        bit   drp;

        e = ref_div(16'sd100, 16'sd7);
        chk("model 100/7 q", e.q, 14);
        e = ref_div(-16'sd100, -16'sd7);
        chk("model -100/-7 r", e.r, -2);
        e = ref_div(-16'sd32768, -16'sd1);
        chk("model min/-1 q", e.q, -32768);

        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        launch(100, 7);     wait_done(1'b1, 5, mk(14, 2, 0, 0), "100/7");
        launch(-100, 7);    wait_done(1'b1, 0, mk(-14, -2, 0, 0), "-100/7");
        launch(100, -7);    wait_done(1'b1, 0, mk(-14, 2, 0, 0), "100/-7");
        launch(-100, -7);   wait_done(1'b1, 0, mk(14, -2, 0, 0), "-100/-7");
        launch(5, 0);       wait_done(1'b1, 0, mk(-1, 5, 1, 0), "5/0");
        launch(-32768, -1); wait_done(1'b1, 0, mk(-32768, 0, 0, 1), "min/-1");
        launch(9, 3);       wait_done(1'b1, 0, mk(3, 0, 0, 0), "9/3");

        launch(20, 3);      wait_done(1'b0, 0, mk(6, 2, 0, 0), "b2b first");
        dividend = -16'sd50;
        divisor  = 16'sd6;
        wait_done(1'b1, 0, mk(-8, -2, 0, 0), "b2b second");

        launch(1234, 5);
        repeat (8) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk_zero("abort");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        launch(1000, 10);   wait_done(1'b1, 0, mk(100, 0, 0, 0), "1000/10");

        for (int i = 0; i < 150; i++) begin
            a   = $signed(WL'($urandom));
            sel = $urandom_range(0, 9);
            case (sel)
                0: b = 0;
                1: begin
                    b = -1;
                    if ($urandom_range(0, 1) == 1) a = -32768;
                end
                2, 3, 4: b = $signed($urandom_range(0, 40)) - 20;
                default: b = $signed(WL'($urandom));
            endcase
            launch(a, b);
            e   = ref_div(WL'(a), WL'(b));
            drp = ($urandom_range(0, 3) != 0) || (i == 149);
            g   = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 15) : 0;
            wait_done(drp, g, e, "rnd");
        end

        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
